// File: rtl/ddram_arbiter.sv
// Round-robin arbiter sharing one 64-bit Avalon-MM DDR port between two requesters.
// Read-return beats are routed back to their issuer through an in-order owner-tag FIFO.
module ddram_arbiter #(
  parameter int TAG_DEPTH = 4,
  parameter int BURST_W   = 8
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [28:0]        a_addr,
  input  logic [BURST_W-1:0] a_burstcnt,
  input  logic               a_rd,
  input  logic               a_we,
  input  logic [63:0]        a_din,
  input  logic [7:0]         a_be,
  output logic               a_busy,
  output logic [63:0]        a_dout,
  output logic               a_dout_ready,
  input  logic [28:0]        b_addr,
  input  logic [BURST_W-1:0] b_burstcnt,
  input  logic               b_rd,
  input  logic               b_we,
  input  logic [63:0]        b_din,
  input  logic [7:0]         b_be,
  output logic               b_busy,
  output logic [63:0]        b_dout,
  output logic               b_dout_ready,
  output logic [28:0]        ram_address,
  output logic [BURST_W-1:0] ram_burstcount,
  output logic               ram_read,
  output logic               ram_write,
  output logic [63:0]        ram_writedata,
  output logic [7:0]         ram_byteenable,
  input  logic               ram_waitrequest,
  input  logic [63:0]        ram_readdata,
  input  logic               ram_readdatavalid
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_FULL = CW'(TAG_DEPTH);
  localparam logic [PW-1:0]      PTR_ZERO = PW'(0);
  localparam logic [PW-1:0]      PTR_ONE  = PW'(1);
  localparam logic [BURST_W-1:0] BC_ZERO  = BURST_W'(0);
  localparam logic [BURST_W-1:0] BC_ONE   = BURST_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    WBURST  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               owner_r, owner_s;            // 0 = A, 1 = B
  logic               last_grant_r, last_grant_s;  // 0 = A, 1 = B
  logic [BURST_W-1:0] beat_cnt_r, beat_cnt_s;
  logic [28:0]        addr_r;
  logic [BURST_W-1:0] burst_r;
  logic               load_s, push_s, pop_s, busy_sel_s;

  logic [28:0]        sel_addr_s;
  logic [BURST_W-1:0] sel_burst_s, burst_eff_s;
  logic               sel_rd_s, sel_we_s, x_rd_s, x_req_s;
  logic [63:0]        sel_din_s;
  logic [7:0]         sel_be_s;
  logic               req_a_s, req_b_s;

  logic               tag_owner_r [TAG_DEPTH];
  logic [BURST_W-1:0] tag_burst_r [TAG_DEPTH];
  logic [PW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [BURST_W-1:0] rtn_cnt_r, remain_s;
  logic               tag_full_s, tag_empty_s, rtn_take_s;

  assign req_a_s     = a_rd | a_we;
  assign req_b_s     = b_rd | b_we;
  assign x_rd_s      = sel_rd_s & ~sel_we_s;  // write wins when both are raised
  assign x_req_s     = sel_rd_s | sel_we_s;
  assign burst_eff_s = (sel_burst_s == BC_ZERO) ? BC_ONE : sel_burst_s;
  assign tag_full_s  = (count_r == CNT_FULL);
  assign tag_empty_s = (count_r == CNT_ZERO);

  // Route the granted requester onto the shared command path
  always_comb begin
    if (owner_r) begin
      sel_addr_s = b_addr; sel_burst_s = b_burstcnt; sel_rd_s = b_rd;
      sel_we_s   = b_we;   sel_din_s   = b_din;      sel_be_s = b_be;
    end else begin
      sel_addr_s = a_addr; sel_burst_s = a_burstcnt; sel_rd_s = a_rd;
      sel_we_s   = a_we;   sel_din_s   = a_din;      sel_be_s = a_be;
    end
  end

  // Arbitration FSM next state and ram command drive
  always_comb begin
    state_s        = state_r;
    owner_s        = owner_r;
    last_grant_s   = last_grant_r;
    beat_cnt_s     = beat_cnt_r;
    load_s         = 1'b0;
    push_s         = 1'b0;
    busy_sel_s     = 1'b1;
    ram_read       = 1'b0;
    ram_write      = 1'b0;
    ram_address    = sel_addr_s;
    ram_burstcount = burst_eff_s;
    ram_writedata  = sel_din_s;
    ram_byteenable = sel_be_s;
    case (state_r)
      IDLE: begin
        if (req_a_s & (~req_b_s | last_grant_r)) begin
          state_s = GRANT_A; owner_s = 1'b0; last_grant_s = 1'b0;
        end else if (req_b_s) begin
          state_s = GRANT_B; owner_s = 1'b1; last_grant_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_A, GRANT_B: begin
        ram_read   = x_rd_s & ~tag_full_s;
        ram_write  = sel_we_s;
        busy_sel_s = ram_waitrequest | (x_rd_s & tag_full_s);
        if (ram_write & ~ram_waitrequest) begin
          if (sel_burst_s <= BC_ONE) begin
            state_s = IDLE;
          end else begin
            beat_cnt_s = sel_burst_s - BC_ONE;
            load_s     = 1'b1;
            state_s    = WBURST;
          end
        end else if (ram_read & ~ram_waitrequest) begin
          push_s  = 1'b1;
          state_s = IDLE;
        end else if (~x_req_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      WBURST: begin
        ram_write      = sel_we_s;
        ram_address    = addr_r;
        ram_burstcount = burst_r;
        busy_sel_s     = ram_waitrequest;
        if (ram_write & ~ram_waitrequest) begin
          beat_cnt_s = beat_cnt_r - BC_ONE;
          if (beat_cnt_r <= BC_ONE) state_s = IDLE;
          else                      state_s = WBURST;
        end else begin
          state_s = WBURST;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Waitrequest back to each requester: only the owner ever sees the real one
  always_comb begin
    if (state_r == IDLE) begin
      a_busy = 1'b1; b_busy = 1'b1;
    end else if (owner_r) begin
      a_busy = 1'b1; b_busy = busy_sel_s;
    end else begin
      a_busy = busy_sel_s; b_busy = 1'b1;
    end
  end

  // FSM state, grant history and write-burst bookkeeping
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      beat_cnt_r   <= BC_ZERO;
      addr_r       <= 29'd0;
      burst_r      <= BC_ZERO;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      beat_cnt_r   <= beat_cnt_s;
      if (load_s) begin
        addr_r  <= sel_addr_s;
        burst_r <= burst_eff_s;
      end
    end
  end

  assign remain_s   = (rtn_cnt_r == BC_ZERO) ? tag_burst_r[rd_ptr_r] : rtn_cnt_r;
  assign rtn_take_s = ram_readdatavalid & ~tag_empty_s;
  assign pop_s      = rtn_take_s & (remain_s == BC_ONE);

  // Owner-tag FIFO; full is judged on the registered count so a pop never frees a slot early
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_owner_r[i] <= 1'b0;
        tag_burst_r[i] <= BC_ZERO;
      end
    end else begin
      if (push_s) begin
        tag_owner_r[wr_ptr_r] <= owner_r;
        tag_burst_r[wr_ptr_r] <= burst_eff_s;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Register read-return beats to the head tag's owner; beats with no tag are dropped
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rtn_cnt_r    <= BC_ZERO;
      a_dout       <= 64'd0;
      b_dout       <= 64'd0;
      a_dout_ready <= 1'b0;
      b_dout_ready <= 1'b0;
    end else if (rtn_take_s) begin
      rtn_cnt_r <= remain_s - BC_ONE;
      if (tag_owner_r[rd_ptr_r]) begin
        b_dout       <= ram_readdata;
        b_dout_ready <= 1'b1;
        a_dout_ready <= 1'b0;
      end else begin
        a_dout       <= ram_readdata;
        a_dout_ready <= 1'b1;
        b_dout_ready <= 1'b0;
      end
    end else begin
      a_dout_ready <= 1'b0;
      b_dout_ready <= 1'b0;
    end
  end

endmodule
